// File: rtl/ring_sched.sv
// ring_sched -- sequencer for the systolic-ring accumulation datapath.
//
// Repeats the following for a host-programmed number of passes:
//   1. Collects a PHASES-word operand vector from the host stream.
//   2. Releases the ring from reset so the PE phase counter starts at 0.
//   3. Injects one operand per cycle.
//   4. Samples the last PE's y output.
//   5. Offers the sampled value on a valid/ready result stream.
//
// Optional feature macro: RING_SCHED_ABORT_EN (adds the `abort` input).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start, pass_count       start request (IDLE only) and pass count (0 -> 1)
//   busy, done              busy in every non-IDLE state; done pulses after the final pass
//   in_valid/in_data/in_ready     operand stream (ready only in LOAD)
//   pe_reset, pe_x, pe_x_init     ring control, injected operand, reset load value
//   ring_y                  y of the last PE in the ring
//   out_valid/out_data/out_ready  result stream
//   abort                   (RING_SCHED_ABORT_EN only) return to IDLE from any busy state

module ring_sched #(
    parameter int W      = 16,
    parameter int PHASES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   pass_count,
    output logic         busy,
    output logic         done,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         pe_reset,
    output logic [W-1:0] pe_x,
    output logic [W-1:0] pe_x_init,
    input  logic [W-1:0] ring_y,
    output logic         out_valid,
    output logic [W-1:0] out_data,
`ifdef RING_SCHED_ABORT_EN
    input  logic         abort,
`endif
    input  logic         out_ready
);

    localparam int IW = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PHASES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_buf [PHASES];
    logic [IW-1:0]  r_ld_idx;
    logic [IW-1:0]  r_ph;
    logic [7:0]     r_passes_left;
    logic [W-1:0]   r_result;
    logic           r_done;
    logic           w_accept;
    logic           w_abort;

    assign w_accept = (r_state == S_LOAD) && in_valid;

`ifdef RING_SCHED_ABORT_EN
    // Abort only matters once a sequence is in flight; in IDLE start wins.
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        pe_reset     = 1'b1;
        pe_x         = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_ld_idx == LAST_IDX)) w_state_next = S_RUN;
            end
            S_RUN: begin
                // pe_reset is a pure decode of the state register, so the PE
                // counter leaves reset exactly at the first RUN cycle.
                pe_reset = 1'b0;
                pe_x     = r_buf[r_ph];
                if (r_ph == LAST_IDX) w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = (r_passes_left == 8'd1) ? S_IDLE : S_LOAD;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_abort) w_state_next = S_IDLE;
    end

    // Operand buffer: one register per phase, written at the load index
    genvar gi;
    generate
        for (gi = 0; gi < PHASES; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_buf[gi] <= '0;
                end else if (w_accept && (r_ld_idx == IW'(gi))) begin
                    r_buf[gi] <= in_data;
                end
            end
        end
    endgenerate

    // Sequencing counters, result capture and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld_idx      <= '0;
            r_ph          <= '0;
            r_passes_left <= '0;
            r_result      <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_passes_left <= (pass_count == 8'd0) ? 8'd1 : pass_count;
                        r_ld_idx      <= '0;
                    end
                end
                S_LOAD: begin
                    r_ph <= '0;
                    if (in_valid) r_ld_idx <= r_ld_idx + 1'b1;
                end
                S_RUN: begin
                    r_ph <= r_ph + 1'b1;
                end
                S_CAPTURE: begin
                    r_result <= ring_y;
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        r_passes_left <= r_passes_left - 8'd1;
                        r_ld_idx      <= '0;
                        if (r_passes_left == 8'd1) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
            // An aborted sequence never reports completion.
            if (w_abort) r_done <= 1'b0;
        end
    end

    assign done      = r_done;
    assign out_data  = r_result;
    assign pe_x_init = r_result;

endmodule

// File: doc/ring_sched.md
# ring_sched

Sequencer for the systolic-ring accumulation datapath. Each ring processing element (PE) runs a free-running 4-phase counter: phases 0–2 accumulate `x*a`, and phase 3 emits `sum + x*a` on `y`. This block:
- accepts 4-word operand vectors from a host stream;
- holds the ring in reset between passes and releases it aligned to phase 0;
- injects one operand per cycle;
- captures the ring result;
- returns it on a valid/ready output stream.

It repeats this for a host-programmed number of passes.

## Interface
Parameters:
- `W`, 16, datapath width. Must match the PE width.
- `PHASES`, 4, PE accumulation length. Fixed by the PE counter; not user-tunable.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request, sampled only in IDLE.
- `pass_count` in 8: number of passes, latched on `start`. A value of 0 is treated as 1.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last pass drains.
- `in_valid` in 1, `in_data` in W, `in_ready` out 1: operand stream.
- `pe_reset` out 1: drives the PE `reset` pins.
- `pe_x` out W: operand injected into the ring.
- `pe_x_init` out W: value loaded into PE `ym` while in reset.
- `ring_y` in W: `y` of the last PE in the ring.
- `out_valid` out 1, `out_data` out W, `out_ready` in 1: result stream.

## Operation
FSM states: IDLE, LOAD, RUN, CAPTURE, DRAIN.
- **IDLE:** `start`=1 latches `pass_count` into `passes_left` (0→1), clears `ld_idx`, and goes to LOAD.
- **LOAD:**
  - `in_ready`=1.
  - Each `in_valid&&in_ready` writes `buf[ld_idx]` and increments `ld_idx`.
  - On the 4th accept, go to RUN with `ph`=0.
- **RUN:**
  - `pe_x`=`buf[ph]`, `ph` increments each cycle.
  - After `ph`=3, go to CAPTURE.
- **CAPTURE:**
  - On the exiting edge, `result`<=`ring_y`; go to DRAIN.
  - `pe_reset`=1 is asserted during CAPTURE, so PE `ym` returns to `x_init` after the sample edge.
- **DRAIN:**
  - `out_valid`=1, `out_data`=`result`.
  - On `out_valid&&out_ready`: decrement `passes_left`.
  - If the new count is nonzero, clear `ld_idx` and go to LOAD.
  - Otherwise pulse `done` on the following cycle and return to IDLE.

Signal rules:
- `pe_reset` = (state != RUN), registered-equivalent. The PE counter is therefore 0 in the first RUN cycle.
- `pe_x` = 0 outside RUN.
- `pe_x_init` = `result`, so the idle ring presents the last result.
- All arithmetic is modulo 2^W (wrap), matching the PE. The block performs no saturation.
- `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
- `start` outside IDLE is ignored.

Reset values:
- State IDLE.
- `busy`=0, `done`=0, `in_ready`=0, `out_valid`=0.
- `pe_reset`=1.
- `pe_x`=0, `out_data`=0, `pe_x_init`=0.
- `buf` entries cleared; `passes_left`=0.

## Timing
- Latency from `start` (edge E) to `in_ready`=1: 1 cycle.
- From the 4th input handshake at edge E0: RUN occupies E0–E4; CAPTURE samples at E5; `out_valid` is high after E5, i.e. 5 cycles.
- Minimum pass period with `in_valid` and `out_ready` held high: 4 (LOAD) + 4 (RUN) + 1 (CAPTURE) + 1 (DRAIN) = 10 cycles.
- `done` is high exactly 1 cycle, the cycle after the final output handshake. `busy` falls in that same cycle.
- `in_ready` is never high outside LOAD. Words offered in other states are not consumed.
- Synchronous `reset` mid-operation: on the next edge all state returns to its reset values. A partial `buf` is discarded, no `done` is produced, and `pe_reset` stays 1.

## Configuration
Macro: `RING_SCHED_ABORT_EN`.
- **Defined:**
  - Adds the input port `abort` (1 bit).
  - `abort`=1 in any non-IDLE state forces IDLE on the next edge: `pe_reset`=1, `out_valid`=0, `done` not pulsed, `result` retained.
  - `abort` in IDLE has no effect. If `abort` and `start` are both high in IDLE, `start` wins.
- **Undefined:** no `abort` port. Sequences end only via completion or `reset`.

## Test plan
Test 1, single pass:
- Stimulus: bench PE model with `a`=2, `pass_count`=1, input 1,2,3,4.
- Required: `out_data`=0x0014 five cycles after the 4th accept, then `done` one cycle after `out_ready`.

Test 2, multiple passes:
- Stimulus: `pass_count`=3 with vectors {1,1,1,1}, {0xFFFF,1,0,0}, {5,0,0,0}, `a`=1.
- Required outputs 0x0004, 0x0000 (wrap), 0x0005; exactly one `done`.

Test 3, back-pressure:
- Stimulus: hold `out_ready`=0 for 7 cycles in DRAIN.
- Required: `out_valid` and `out_data` stay stable, `in_ready`=0, `pe_reset`=1 throughout; single handshake on release.

Test 4, bubbles and ignored start:
- Stimulus: gap `in_valid` low between words; assert `start` while busy.
- Required: RUN starts only after the 4th accept; `pass_count` is not re-latched.

Test 5, reset mid-sequence:
- Stimulus: `reset` in RUN at `ph`=2.
- Required next cycle: IDLE, `pe_reset`=1, `out_valid`=0, no `done`. A following run with 1,2,3,4 and `a`=2 gives 0x0014.

Test 6, abort (`RING_SCHED_ABORT_EN` defined):
- Stimulus: `abort` in LOAD after 2 words.
- Required: IDLE next cycle, `busy`=0, no output, no `done`.
